// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: widths, the schedule word type, the small-sigma
// functions used by the message schedule and the compression core, and the
// 3:2 carry-save helpers used to build the schedule adder tree.
package sha256_pkg;

    localparam int WORD_W  = 32;
    localparam int ROUNDS  = 64;
    localparam int BLOCK_W = 512;

    typedef logic [31:0] word_t;

    // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
    function automatic word_t ssig0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
    function automatic word_t ssig1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b00_0000_0000, x[31:10]};
    endfunction

    // Sum output of a bitwise full-adder row.
    function automatic word_t csa_sum(input word_t a, input word_t b, input word_t c);
        return a ^ b ^ c;
    endfunction

    // Carry output of a bitwise full-adder row, already shifted into weight
    // position; the carry out of bit 31 is dropped because all sums are mod 2^32.
    function automatic word_t csa_carry(input word_t a, input word_t b, input word_t c);
        word_t maj;
        maj = (a & b) | (a & c) | (b & c);
        return {maj[30:0], 1'b0};
    endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule. Loads a 512-bit block on an accepted start and
// emits W0..W63, one per cycle, in lockstep with the external round counter.
// A sticky sync_err flags any active cycle where the counter's round index
// disagrees with the internal index; the datapath itself is never disturbed.
module sha256_msg_schedule
    import sha256_pkg::word_t, sha256_pkg::BLOCK_W, sha256_pkg::ssig0, sha256_pkg::ssig1,
           sha256_pkg::csa_sum, sha256_pkg::csa_carry;
#(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BLOCK_W-1:0]   block_in,
    input  logic [5:0]           round,
    output logic [WORD_W-1:0]    w_out,
    output logic                 w_valid,
    output logic                 w_last,
    output logic                 busy,
    output logic                 sync_err
);

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    logic       active_q, active_d;
    logic [5:0] idx_q,    idx_d;
    logic       sync_err_q, sync_err_d;
    word_t      w_q [16];
    word_t      w_d [16];

    // Adder tree intermediates for the next window word.
    word_t      sig1_s, sig0_s;
    word_t      csa1_sum_s, csa1_carry_s;
    word_t      csa2_sum_s, csa2_carry_s;
    word_t      w_new_s;

    // Next schedule word: two carry-save rows reduce the four operands to two,
    // then a single carry-propagate add closes the sum mod 2^32.
    always_comb begin
        sig1_s       = ssig1(w_q[14]);
        sig0_s       = ssig0(w_q[1]);
        csa1_sum_s   = csa_sum(sig1_s, w_q[9], sig0_s);
        csa1_carry_s = csa_carry(sig1_s, w_q[9], sig0_s);
        csa2_sum_s   = csa_sum(csa1_sum_s, csa1_carry_s, w_q[0]);
        csa2_carry_s = csa_carry(csa1_sum_s, csa1_carry_s, w_q[0]);
        w_new_s      = csa2_sum_s + csa2_carry_s;
    end

    // Next-state logic: block load when idle, window shift and index advance
    // when active, sticky round-sync check.
    always_comb begin
        active_d   = active_q;
        idx_d      = idx_q;
        sync_err_d = sync_err_q;
        w_d        = w_q;
        if (!active_q) begin
            if (start) begin
                // M0 sits in the top word of the big-endian block.
                for (int i = 0; i < 16; i++) begin
                    w_d[i] = block_in[BLOCK_W-1-32*i -: 32];
                end
                idx_d      = 6'd0;
                active_d   = 1'b1;
                sync_err_d = 1'b0;
            end else begin
                active_d = 1'b0;
            end
        end else begin
            for (int i = 0; i < 15; i++) begin
                w_d[i] = w_q[i+1];
            end
            w_d[15] = w_new_s;
            if (idx_q == LAST_IDX) begin
                active_d = 1'b0;
                idx_d    = 6'd0;
            end else begin
                idx_d = idx_q + 6'd1;
            end
            if (round != idx_q) begin
                sync_err_d = 1'b1;
            end else begin
                sync_err_d = sync_err_q;
            end
        end
    end

    // State registers; reset drops any block in flight immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q   <= 1'b0;
            idx_q      <= 6'd0;
            sync_err_q <= 1'b0;
            w_q        <= '{default: 32'h0000_0000};
        end else begin
            active_q   <= active_d;
            idx_q      <= idx_d;
            sync_err_q <= sync_err_d;
            w_q        <= w_d;
        end
    end

    // Outputs are flop values gated by the active flag, so they are zero
    // whenever no block is in progress.
    always_comb begin
        if (active_q) begin
            w_out   = w_q[0];
            w_valid = 1'b1;
            w_last  = (idx_q == LAST_IDX);
            busy    = 1'b1;
        end else begin
            w_out   = 32'h0000_0000;
            w_valid = 1'b0;
            w_last  = 1'b0;
            busy    = 1'b0;
        end
        sync_err = sync_err_q;
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed, scoreboard-based bench for sha256_msg_schedule with an attached
// round-counter model that shares the start strobe.
module tb_sha256_msg_schedule;

    logic         clk;
    logic         rst;
    logic         start;
    logic [511:0] block_in;
    logic [5:0]   round;
    logic [31:0]  w_out;
    logic         w_valid;
    logic         w_last;
    logic         busy;
    logic         sync_err;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_w_q [$];
    logic        exp_last_q [$];

    // Round counter model: one idle cycle between runs, ignores start while counting.
    logic       cnt_active;
    logic [5:0] cnt;
    logic [5:0] skew;

    localparam logic [511:0] ABC_BLK = {32'h6162_6380, {14{32'h0000_0000}}, 32'h0000_0018};

    sha256_msg_schedule dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .block_in (block_in),
        .round    (round),
        .w_out    (w_out),
        .w_valid  (w_valid),
        .w_last   (w_last),
        .busy     (busy),
        .sync_err (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_active <= 1'b0;
            cnt        <= 6'd0;
        end else if (!cnt_active) begin
            if (start) begin
                cnt_active <= 1'b1;
                cnt        <= 6'd0;
            end
        end else if (cnt == 6'd63) begin
            cnt_active <= 1'b0;
            cnt        <= 6'd0;
        end else begin
            cnt <= cnt + 6'd1;
        end
    end

    assign round = cnt + skew;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference schedule for one block, pushed onto the scoreboard.
    task automatic push_block(input logic [511:0] blk);
        logic [31:0] w [64];
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = ref_s1(w[i-2]) + w[i-7] + ref_s0(w[i-15]) + w[i-16];
        for (int i = 0; i < 64; i++) begin
            exp_w_q.push_back(w[i]);
            exp_last_q.push_back(i == 63);
        end
    endtask

    // One active cycle: pop the scoreboard and compare.
    task automatic active_cycle(input string tag);
        logic [31:0] ew;
        logic        el;
        @(negedge clk);
        chk({tag, ".valid"}, {31'd0, w_valid}, 32'd1);
        chk({tag, ".busy"},  {31'd0, busy},    32'd1);
        if (exp_w_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            ew = exp_w_q.pop_front();
            el = exp_last_q.pop_front();
            chk({tag, ".w_out"},  w_out,            ew);
            chk({tag, ".w_last"}, {31'd0, w_last},  {31'd0, el});
        end
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge clk);
        chk({tag, ".valid"}, {31'd0, w_valid}, 32'd0);
        chk({tag, ".busy"},  {31'd0, busy},    32'd0);
        chk({tag, ".w_last"}, {31'd0, w_last}, 32'd0);
        chk({tag, ".w_out"}, w_out,            32'd0);
    endtask

    initial begin
        logic [511:0] blk_b, blk_c, blk_d, blk_e, blk_g;
        for (int i = 0; i < 16; i++) begin
            blk_b[32*i +: 32] = $urandom;
            blk_c[32*i +: 32] = $urandom;
            blk_d[32*i +: 32] = $urandom;
            blk_e[32*i +: 32] = $urandom;
            blk_g[32*i +: 32] = $urandom;
        end
        rst      = 1'b1;
        start    = 1'b0;
        block_in = '0;
        skew     = 6'd0;

        // Reset state.
        #12;
        chk("rst.w_out",    w_out,              32'd0);
        chk("rst.w_valid",  {31'd0, w_valid},   32'd0);
        chk("rst.sync_err", {31'd0, sync_err},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) idle_cycle("noact");
        chk("noact.sync_err", {31'd0, sync_err}, 32'd0);

        // "abc" block with known early words.
        block_in = ABC_BLK;
        start    = 1'b1;
        push_block(ABC_BLK);
        for (int t = 0; t < 64; t++) begin
            active_cycle("abc");
            if (t == 0)  begin start = 1'b0; block_in = '1; chk("abc.W0", w_out, 32'h6162_6380); end
            if (t == 15) chk("abc.W15", w_out, 32'h0000_0018);
            if (t == 16) chk("abc.W16", w_out, 32'h6162_6380);
            if (t == 17) chk("abc.W17", w_out, 32'h000F_0000);
        end
        idle_cycle("abc.end");
        chk("abc.sync_err", {31'd0, sync_err}, 32'd0);

        // Back-to-back blocks with start held high.
        block_in = blk_b;
        start    = 1'b1;
        push_block(blk_b);
        push_block(blk_c);
        for (int t = 0; t < 64; t++) begin
            active_cycle("b2b1");
            if (t == 0) block_in = blk_c;
        end
        idle_cycle("b2b.gap");
        for (int t = 0; t < 64; t++) begin
            active_cycle("b2b2");
            if (t == 63) start = 1'b0;
        end
        chk("b2b.sync_err", {31'd0, sync_err}, 32'd0);
        idle_cycle("b2b.end");
        idle_cycle("b2b.end2");

        // Start pulses during rounds 5 and 63 are ignored.
        block_in = blk_d;
        start    = 1'b1;
        push_block(blk_d);
        for (int t = 0; t < 64; t++) begin
            active_cycle("ign");
            if (t == 0)  begin start = 1'b0; block_in = blk_b; end
            if (t == 5)  start = 1'b1;
            if (t == 6)  start = 1'b0;
            if (t == 63) start = 1'b1;
        end
        idle_cycle("ign.end");
        start = 1'b0;
        idle_cycle("ign.end2");
        chk("ign.sb_drained", exp_w_q.size(), 32'd0);

        // Round skew at round 20 sets the sticky sync error only.
        block_in = blk_e;
        start    = 1'b1;
        push_block(blk_e);
        for (int t = 0; t < 64; t++) begin
            active_cycle("skew");
            if (t < 20)  chk("skew.pre",  {31'd0, sync_err}, 32'd0);
            if (t > 20)  chk("skew.post", {31'd0, sync_err}, 32'd1);
            if (t == 0)  start = 1'b0;
            if (t == 19) skew = 6'd1;
            if (t == 20) skew = 6'd0;
        end
        idle_cycle("skew.end");
        chk("skew.sticky", {31'd0, sync_err}, 32'd1);

        // Next start clears sync_err; reset during round 30 aborts the block.
        block_in = ABC_BLK;
        start    = 1'b1;
        push_block(ABC_BLK);
        for (int t = 0; t <= 30; t++) begin
            active_cycle("abort");
            if (t == 0) begin start = 1'b0; chk("abort.clr", {31'd0, sync_err}, 32'd0); end
        end
        rst = 1'b1;
        #1;
        chk("arst.w_out",   w_out,             32'd0);
        chk("arst.w_valid", {31'd0, w_valid},  32'd0);
        chk("arst.w_last",  {31'd0, w_last},   32'd0);
        chk("arst.busy",    {31'd0, busy},     32'd0);
        chk("arst.sync",    {31'd0, sync_err}, 32'd0);
        exp_w_q.delete();
        exp_last_q.delete();
        @(negedge clk);
        rst = 1'b0;
        idle_cycle("arst.idle");

        // Fresh schedule after the aborted block.
        block_in = blk_g;
        start    = 1'b1;
        push_block(blk_g);
        for (int t = 0; t < 64; t++) begin
            active_cycle("fresh");
            if (t == 0) start = 1'b0;
        end
        idle_cycle("fresh.end");
        chk("fresh.sync_err", {31'd0, sync_err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_msg_schedule.md
# sha256_msg_schedule

Message-schedule stage for the SHA-256 compression datapath. It sits directly downstream of the 64-round counter and shares its `start` strobe. It takes one 512-bit block and emits one 32-bit schedule word W_t per active round, t = 0..63, in lockstep with the counter's `count`. It also checks that the counter's round index matches its own, so the compression core can trust `w_out` at every round.

## Interface

Parameters
- `WORD_W`, 32: schedule word width. Fixed for SHA-256; exists only for package consistency.
- `ROUNDS`, 64: rounds per block. Must match the counter's terminal count + 1.

Ports
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  same strobe that drives the round counter; accepted only when idle.
- `block_in`  in  512  message block, big-endian; M0 = `block_in[511:480]`, M15 = `block_in[31:0]`.
- `round`  in  6  round index from the counter's `count`.
- `w_out`  out  32  current schedule word W_t.
- `w_valid`  out  1  high for exactly the 64 active cycles of a block.
- `w_last`  out  1  high on the cycle carrying W63.
- `busy`  out  1  high from the cycle after accepted start through the W63 cycle.
- `sync_err`  out  1  sticky flag: `round` disagreed with internal index during an active cycle.

## Operation

- State is `IDLE` or `ACTIVE`, held in a 1-bit active flag. Internal storage:
  - `idx[5:0]`
  - a 16-entry × 32-bit shift window `w[0..15]`, where `w[0]` is the oldest word.
- `IDLE` with `start`=1:
  - load `w[i]` = M_i for i = 0..15
  - `idx` <= 0
  - go to `ACTIVE`
  - clear `sync_err`
- `IDLE` with `start`=0: hold all state.
- `ACTIVE` (combinational outputs):
  - `w_out` = `w[0]`
  - `w_valid` = 1
  - `w_last` = (`idx`==63)
  - `busy` = 1
- `ACTIVE`, each cycle:
  - shift: `w[i]` <= `w[i+1]` for i = 0..14.
  - `w[15]` <= σ1(`w[14]`) + `w[9]` + σ0(`w[1]`) + `w[0]`, computed mod 2^32.
  - `idx` <= `idx`+1.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- `ACTIVE` with `idx`==63: return to `IDLE`, `idx` <= 0. The 6-bit wrap is intended.
- `start` during `ACTIVE` is ignored. The counter also ignores it while counting, so the two blocks stay aligned.
- Sync check: if `ACTIVE` and `round` != `idx`, set `sync_err` <= 1. It holds until `rst` or the next accepted `start`. The datapath is not stalled or altered by a mismatch.
- When not `ACTIVE`:
  - `w_out` = 0, `w_valid` = 0, `w_last` = 0, `busy` = 0.
  - `round` is not checked.

## Timing

- Reset values:
  - active flag = 0, `idx` = 0, `w[*]` = 0
  - `w_out` = 0, `w_valid` = 0, `w_last` = 0, `busy` = 0, `sync_err` = 0
- Latency: `start` sampled at edge E0. W0 appears after E0 and remains valid until E1. Wt is valid in the cycle between E_t and E_(t+1), which is the cycle in which the counter shows `count`=t.
- A block occupies exactly 64 `w_valid` cycles. The earliest next `start` is accepted on the edge that retires W63. If that `start` is accepted, `w_valid` drops for one cycle, then W0 of the new block appears. This matches the counter's one idle cycle between runs.
- Reset mid-block returns the block to `IDLE` immediately, asynchronously, with all outputs at reset values. No partial block resumes.
- `block_in` is sampled only on the accepted-start edge. It may change freely afterwards.
- Critical path: σ1 + σ0 + a 4-input 32-bit add. Implement as a carry-save (3:2) tree followed by one carry-propagate adder (CPA).

## Structure

- `sha256_pkg` contains:
  - `WORD_W`, `ROUNDS`, `BLOCK_W`=512
  - `typedef logic [31:0] word_t`
  - functions `ssig0`, `ssig1`, used here and by the compression core
- No sub-module. The σ functions live in the package, and the window is a plain `word_t` array.

## Test plan

- Reset, then no `start` for 10 cycles: all outputs stay at 0.
- Send `start` with the "abc" block (M0 = 0x61626380, M1–M14 = 0, M15 = 0x00000018):
  - W0 = 0x61626380 and W15 = 0x00000018.
  - W16 = 0x61626380 and W17 = 0x000F0000.
  - W18–W63 match the reference model.
  - `w_last` appears only with W63.
- Back-to-back blocks, with `start` held high throughout and the counter model attached:
  - exactly one idle cycle between blocks;
  - second-block W0 correct;
  - `sync_err` = 0.
- `start` pulses during rounds 5 and 63: ignored, no reload, and the schedule is unchanged.
- Skew `round` by +1 in round 20: `sync_err` rises in that cycle and stays high to the end. The W values are unaffected. The next `start` clears `sync_err`.
- Assert `rst` during round 30: all outputs are 0 immediately. A subsequent `start` produces a correct fresh schedule.
